// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl
//   Fetch sequencer for a combinational, word-addressed instruction memory.
//   Owns the program counter, drives the memory address, captures each
//   returned instruction together with its PC into a 2-entry FIFO and hands
//   the head to decode over a valid/ready handshake. Supports start-up from
//   IDLE, redirects with buffer flush, and a sticky fault on misaligned
//   redirect targets.
//
// Ports
//   clk            in   1   clock, rising edge
//   rst            in   1   asynchronous, active-high reset
//   start          in   1   leave IDLE and begin fetching
//   imem_addr      out  64  instruction memory address (= PC register)
//   imem_instr     in   32  instruction memory data for imem_addr
//   redirect_valid in   1   restart fetch at redirect_pc
//   redirect_pc    in   64  redirect target
//   out_valid      out  1   buffer head holds an instruction
//   out_instr      out  32  head instruction (0 when out_valid=0)
//   out_pc         out  64  head PC (0 when out_valid=0)
//   out_ready      in   1   decode accepts the head this cycle
//   fault          out  1   sticky misaligned-redirect flag

module instr_fetch_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    input  logic        out_ready,
    output logic        fault
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t      state;
    logic [63:0] pc;
    logic [1:0]  count;
    logic        fault_flag;

    // Buffer storage: slot 0 is always the head, slot 1 the second entry.
    logic [31:0] instr0, instr1;
    logic [63:0] pc0, pc1;

    logic        pop;
    logic        push;
    logic        misaligned;
    logic [1:0]  level_after_pop;

    assign misaligned      = (redirect_pc[1:0] != 2'b00);
    assign pop             = out_valid & out_ready;
    assign push            = (state == RUN) & ~redirect_valid & ((count != 2'd2) | pop);
    assign level_after_pop = count - {1'b0, pop};

    assign imem_addr = pc;
    assign fault     = fault_flag;
    assign out_valid = (count != 2'd0);
    assign out_instr = out_valid ? instr0 : 32'd0;
    assign out_pc    = out_valid ? pc0    : 64'd0;

    // Control: state, PC, occupancy and fault flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            count      <= 2'd0;
            fault_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Redirect wins over start in the same cycle.
                    if (redirect_valid) begin
                        if (misaligned) begin
                            fault_flag <= 1'b1;
                            state      <= FAULT;
                        end else begin
                            pc <= redirect_pc;
                        end
                    end else if (start) begin
                        state <= RUN;
                    end
                end

                RUN: begin
                    if (redirect_valid) begin
                        // Flush; a head popped this cycle is still delivered.
                        count <= 2'd0;
                        if (misaligned) begin
                            fault_flag <= 1'b1;
                            state      <= FAULT;
                        end else begin
                            pc <= redirect_pc;
                        end
                    end else begin
                        if (push) begin
                            pc <= pc + 64'd4;
                        end
                        case ({push, pop})
                            2'b10:   count <= count + 2'd1;
                            2'b01:   count <= count - 2'd1;
                            default: count <= count;
                        endcase
                    end
                end

                FAULT: begin
                    count <= 2'd0;
                end

                default: begin
                    state <= IDLE;
                    count <= 2'd0;
                end
            endcase
        end
    end

    // Buffer data: never read while count=0, so it carries no reset.
    always_ff @(posedge clk) begin
        if (pop) begin
            instr0 <= instr1;
            pc0    <= pc1;
        end
        // New entry lands in the first free slot after this cycle's pop.
        if (push) begin
            if (level_after_pop == 2'd0) begin
                instr0 <= imem_instr;
                pc0    <= pc;
            end else begin
                instr1 <= imem_instr;
                pc1    <= pc;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl
//   Self-checking bench for instr_fetch_ctrl: directed vector table,
//   hand-written multi-cycle sequences (fault, asynchronous reset) and a
//   randomized run against a queue-based reference model.

module tb_instr_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        out_ready;
    logic        fault;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:1023];

    assign imem_instr = mem[imem_addr[11:2]];

    always #5 clk = ~clk;

    instr_fetch_ctrl #(.RESET_PC(64'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready),
        .fault          (fault)
    );

    typedef struct {
        logic        r;
        logic        s;
        logic        rv;
        logic [63:0] rpc;
        logic        rdy;
        logic        ev;
        logic [63:0] epc;
        logic [31:0] ei;
        logic [63:0] ea;
        logic        ef;
    } vec_t;

    vec_t tbl[$];

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } entry_t;

    function automatic vec_t mk(input logic r, input logic s, input logic rv,
                                input logic [63:0] rpc, input logic rdy,
                                input logic ev, input logic [63:0] epc,
                                input logic [31:0] ei, input logic [63:0] ea,
                                input logic ef);
        vec_t t;
        t.r = r; t.s = s; t.rv = rv; t.rpc = rpc; t.rdy = rdy;
        t.ev = ev; t.epc = epc; t.ei = ei; t.ea = ea; t.ef = ef;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic rv,
                         input logic [63:0] rpc, input logic rdy);
        rst            = r;
        start          = s;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
    endtask

    task automatic chk_outs(input string tag, input logic ev, input logic [63:0] epc,
                            input logic [31:0] ei, input logic [63:0] ea, input logic ef);
        chk({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, ev});
        chk({tag, ".out_pc"},    out_pc, epc);
        chk({tag, ".out_instr"}, {32'd0, out_instr}, {32'd0, ei});
        chk({tag, ".imem_addr"}, imem_addr, ea);
        chk({tag, ".fault"},     {63'd0, fault}, {63'd0, ef});
    endtask

    // Drive at negedge, let one rising edge pass, check at the next negedge.
    task automatic cycle(input logic r, input logic s, input logic rv,
                         input logic [63:0] rpc, input logic rdy);
        drive(r, s, rv, rpc, rdy);
        @(negedge clk);
    endtask

    // Reference model state
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_FAULT = 2;

    int          m_state;
    logic [63:0] m_pc;
    logic        m_fault;
    entry_t      m_q[$];

    task automatic model_reset();
        m_state = M_IDLE;
        m_pc    = 64'h0;
        m_fault = 1'b0;
        m_q.delete();
    endtask

    task automatic model_step(input logic s, input logic rv, input logic [63:0] rpc,
                              input logic rdy);
        entry_t e;
        if (m_state == M_FAULT) return;
        if (rv) begin
            if (rpc[1:0] != 2'b00) begin
                m_fault = 1'b1;
                m_state = M_FAULT;
                m_q.delete();
            end else begin
                m_pc = rpc;
                m_q.delete();
            end
        end else if (m_state == M_IDLE) begin
            if (s) m_state = M_RUN;
        end else begin
            if (rdy && m_q.size() > 0) void'(m_q.pop_front());
            if (m_q.size() < 2) begin
                e.pc    = m_pc;
                e.instr = mem[m_pc[11:2]];
                m_q.push_back(e);
                m_pc = m_pc + 64'd4;
            end
        end
    endtask

    task automatic model_check();
        logic        ev;
        logic [63:0] epc;
        logic [31:0] ei;
        ev  = (m_q.size() > 0);
        epc = ev ? m_q[0].pc : 64'd0;
        ei  = ev ? m_q[0].instr : 32'd0;
        chk_outs("rand", ev, epc, ei, m_pc, m_fault);
    endtask

    initial begin
        logic        r_rst, r_s, r_rv, r_rdy;
        logic [63:0] r_pc;

        for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | i;
        mem[0] = 32'h0000_0013;
        mem[1] = 32'h0010_0093;
        mem[2] = 32'h0020_0113;
        mem[3] = 32'h0030_0193;

        drive(1'b1, 1'b0, 1'b0, 64'd0, 1'b0);
        @(negedge clk);

        // Straight-line fetch with decode always ready
        tbl.push_back(mk(1,0,0,64'd0,1, 0,64'd0,32'd0,64'd0,0));
        tbl.push_back(mk(0,1,0,64'd0,1, 0,64'd0,32'd0,64'd0,0));
        tbl.push_back(mk(0,0,0,64'd0,1, 1,64'd0, 32'h0000_0013,64'd4, 0));
        tbl.push_back(mk(0,0,0,64'd0,1, 1,64'd4, 32'h0010_0093,64'd8, 0));
        tbl.push_back(mk(0,0,0,64'd0,1, 1,64'd8, 32'h0020_0113,64'd12,0));
        tbl.push_back(mk(0,0,0,64'd0,1, 1,64'd12,32'h0030_0193,64'd16,0));
        // Back-pressure: buffer fills, PC stalls at 8, then drains in order
        tbl.push_back(mk(1,0,0,64'd0,0, 0,64'd0,32'd0,64'd0,0));
        tbl.push_back(mk(0,1,0,64'd0,0, 0,64'd0,32'd0,64'd0,0));
        tbl.push_back(mk(0,0,0,64'd0,0, 1,64'd0,32'h0000_0013,64'd4,0));
        tbl.push_back(mk(0,0,0,64'd0,0, 1,64'd0,32'h0000_0013,64'd8,0));
        tbl.push_back(mk(0,0,0,64'd0,0, 1,64'd0,32'h0000_0013,64'd8,0));
        tbl.push_back(mk(0,0,0,64'd0,0, 1,64'd0,32'h0000_0013,64'd8,0));
        tbl.push_back(mk(0,0,0,64'd0,0, 1,64'd0,32'h0000_0013,64'd8,0));
        tbl.push_back(mk(0,0,0,64'd0,1, 1,64'd4, 32'h0010_0093,64'd12,0));
        tbl.push_back(mk(0,0,0,64'd0,1, 1,64'd8, 32'h0020_0113,64'd16,0));
        tbl.push_back(mk(0,0,0,64'd0,1, 1,64'd12,32'h0030_0193,64'd20,0));
        // Redirect with full buffer and head accepted in the same cycle
        tbl.push_back(mk(1,0,0,64'd0,0, 0,64'd0,32'd0,64'd0,0));
        tbl.push_back(mk(0,1,0,64'd0,0, 0,64'd0,32'd0,64'd0,0));
        tbl.push_back(mk(0,0,0,64'd0,0, 1,64'd0,32'h0000_0013,64'd4,0));
        tbl.push_back(mk(0,0,0,64'd0,0, 1,64'd0,32'h0000_0013,64'd8,0));
        tbl.push_back(mk(0,0,1,64'h40,1, 0,64'd0,32'd0,64'h40,0));
        tbl.push_back(mk(0,0,0,64'd0,1, 1,64'h40,32'hC0DE_0010,64'h44,0));
        tbl.push_back(mk(0,0,0,64'd0,1, 1,64'h44,32'hC0DE_0011,64'h48,0));
        // IDLE redirect beats start; then PC wrap through 2^64
        tbl.push_back(mk(1,0,0,64'd0,1, 0,64'd0,32'd0,64'd0,0));
        tbl.push_back(mk(0,1,1,64'hFFFF_FFFF_FFFF_FFF8,1, 0,64'd0,32'd0,64'hFFFF_FFFF_FFFF_FFF8,0));
        tbl.push_back(mk(0,0,0,64'd0,1, 0,64'd0,32'd0,64'hFFFF_FFFF_FFFF_FFF8,0));
        tbl.push_back(mk(0,1,0,64'd0,1, 0,64'd0,32'd0,64'hFFFF_FFFF_FFFF_FFF8,0));
        tbl.push_back(mk(0,0,0,64'd0,1, 1,64'hFFFF_FFFF_FFFF_FFF8,32'hC0DE_03FE,64'hFFFF_FFFF_FFFF_FFFC,0));
        tbl.push_back(mk(0,0,0,64'd0,1, 1,64'hFFFF_FFFF_FFFF_FFFC,32'hC0DE_03FF,64'd0,0));
        tbl.push_back(mk(0,0,0,64'd0,1, 1,64'd0,32'h0000_0013,64'd4,0));
        tbl.push_back(mk(0,0,0,64'd0,1, 1,64'd4,32'h0010_0093,64'd8,0));

        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].r, tbl[i].s, tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
            chk_outs($sformatf("vec%0d", i), tbl[i].ev, tbl[i].epc, tbl[i].ei, tbl[i].ea, tbl[i].ef);
        end

        // Misaligned redirect in RUN: sticky fault, frozen PC, inputs ignored
        cycle(1, 0, 0, 64'd0, 0);
        cycle(0, 1, 0, 64'd0, 0);
        cycle(0, 0, 0, 64'd0, 0);
        chk_outs("flt_pre", 1'b1, 64'd0, 32'h0000_0013, 64'd4, 1'b0);
        cycle(0, 0, 1, 64'h42, 0);
        chk_outs("flt_hit", 1'b0, 64'd0, 32'd0, 64'd4, 1'b1);
        cycle(0, 1, 1, 64'h100, 1);
        chk_outs("flt_ign", 1'b0, 64'd0, 32'd0, 64'd4, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 0, 64'd0, 1);
            chk_outs("flt_hold", 1'b0, 64'd0, 32'd0, 64'd4, 1'b1);
        end
        drive(1, 0, 0, 64'd0, 1);
        #1;
        chk_outs("flt_rst", 1'b0, 64'd0, 32'd0, 64'd0, 1'b0);
        @(negedge clk);

        // Asynchronous reset with a full buffer, asserted between edges
        cycle(0, 1, 0, 64'd0, 0);
        cycle(0, 0, 0, 64'd0, 0);
        cycle(0, 0, 0, 64'd0, 0);
        chk_outs("arst_pre", 1'b1, 64'd0, 32'h0000_0013, 64'd8, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_outs("arst_now", 1'b0, 64'd0, 32'd0, 64'd0, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 64'd0, 1);
            chk_outs("arst_idle", 1'b0, 64'd0, 32'd0, 64'd0, 1'b0);
        end

        // Randomized run against the reference model
        cycle(1, 0, 0, 64'd0, 0);
        model_reset();
        model_check();
        for (int n = 0; n < 1500; n++) begin
            r_rst = ($urandom_range(0, 149) == 0);
            r_s   = ($urandom_range(0, 3) == 0);
            r_rdy = ($urandom_range(0, 1) == 1);
            r_rv  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0)
                r_pc = 64'hFFFF_FFFF_FFFF_FF00 + (64'($urandom_range(0, 63)) << 2);
            else
                r_pc = 64'($urandom_range(0, 1023)) << 2;
            if ($urandom_range(0, 7) == 0)
                r_pc[1:0] = 2'($urandom_range(1, 3));
            cycle(r_rst, r_s, r_rv, r_pc, r_rdy);
            if (r_rst) model_reset();
            else model_step(r_s, r_rv, r_pc, r_rdy);
            model_check();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
